// File: rtl/piece_dispatcher.sv
// piece_dispatcher: game-state FSM, per-player current/next piece slots,
// create/created handshake and round-robin refill from one shared piece source.
module piece_dispatcher #(
  parameter int PIECE_W    = 3,
  parameter int NUM_PIECES = 7
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               game_reset,
  input  logic               start_single,
  input  logic               start_multi,
  input  logic [PIECE_W-1:0] rand_piece,
  output logic               rand_take,
  input  logic               finish_block1,
  input  logic               finish_block2,
  input  logic               created1,
  input  logic               created2,
  input  logic               game_over1,
  input  logic               game_over2,
  output logic [PIECE_W-1:0] curr1,
  output logic [PIECE_W-1:0] curr2,
  output logic [PIECE_W-1:0] next1,
  output logic [PIECE_W-1:0] next2,
  output logic               create_block1,
  output logic               create_block2,
  output logic               lock1,
  output logic               lock2,
  output logic               multi,
  output logic [1:0]         game_state,
  output logic [1:0]         winner
);

  localparam logic [PIECE_W:0] NUM_CODES = NUM_PIECES[PIECE_W:0];

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_PLAY, S_OVER} state_t;

  state_t     state, state_nxt;
  logic [1:0] fill_idx;
  logic       pend1, pend2, def1, def2, rr;
  logic       code_ok, fill_done, over_hit;
  logic       grant1, grant2;
  logic       apply1, apply2, defer1, defer2;

  // Event decode shared by the FSM and the datapath
  always_comb begin
    code_ok   = ({1'b0, rand_piece} < NUM_CODES);
    fill_done = (state == S_FILL) && code_ok && (fill_idx == (multi ? 2'd3 : 2'd1));
    over_hit  = (state == S_PLAY) && (game_over1 || (multi && game_over2));
    grant1    = (state == S_PLAY) && pend1 && (!pend2 || !rr);
    grant2    = (state == S_PLAY) && pend2 && (!pend1 || rr);
    // A deferred finish replays once its refill is done; a fresh finish only
    // counts when no spawn is outstanding and nothing is already deferred.
    apply1    = (state == S_PLAY) && !over_hit &&
                ((def1 && !pend1) || (finish_block1 && !create_block1 && !pend1 && !def1));
    defer1    = (state == S_PLAY) && !over_hit && finish_block1 && !create_block1 && pend1;
    apply2    = (state == S_PLAY) && multi && !over_hit &&
                ((def2 && !pend2) || (finish_block2 && !create_block2 && !pend2 && !def2));
    defer2    = (state == S_PLAY) && multi && !over_hit && finish_block2 && !create_block2 && pend2;
  end

  // State register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; game_reset overrides everything
  always_comb begin
    state_nxt = state;
    if (game_reset) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start_single || start_multi) state_nxt = S_FILL;
        S_FILL:  if (fill_done) state_nxt = S_PLAY;
        S_PLAY:  if (over_hit) state_nxt = S_OVER;
        default: state_nxt = state;
      endcase
    end
  end

  // FSM-derived outputs
  always_comb begin
    game_state = 2'd0;
    case (state)
      S_PLAY:  game_state = 2'd1;
      S_OVER:  game_state = 2'd2;
      default: game_state = 2'd0;
    endcase
    rand_take = (state == S_FILL) || grant1 || grant2;
  end

  // Piece slots, handshake flags, refill bookkeeping and result
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fill_idx <= '0; multi <= 1'b0; winner <= '0; rr <= 1'b0;
      curr1 <= '0; curr2 <= '0; next1 <= '0; next2 <= '0;
      create_block1 <= 1'b0; create_block2 <= 1'b0;
      lock1 <= 1'b0; lock2 <= 1'b0;
      pend1 <= 1'b0; pend2 <= 1'b0; def1 <= 1'b0; def2 <= 1'b0;
    end else if (game_reset) begin
      fill_idx <= '0; multi <= 1'b0; winner <= '0; rr <= 1'b0;
      curr1 <= '0; curr2 <= '0; next1 <= '0; next2 <= '0;
      create_block1 <= 1'b0; create_block2 <= 1'b0;
      lock1 <= 1'b0; lock2 <= 1'b0;
      pend1 <= 1'b0; pend2 <= 1'b0; def1 <= 1'b0; def2 <= 1'b0;
    end else begin
      lock1 <= 1'b0;
      lock2 <= 1'b0;
      case (state)
        S_IDLE: begin
          fill_idx <= '0;
          if (start_multi)       multi <= 1'b1;
          else if (start_single) multi <= 1'b0;
        end
        S_FILL: begin
          if (code_ok) begin
            case (fill_idx)
              2'd0: curr1 <= rand_piece;
              2'd1: next1 <= rand_piece;
              2'd2: curr2 <= rand_piece;
              2'd3: next2 <= rand_piece;
            endcase
            fill_idx <= fill_idx + 2'd1;
          end
          if (fill_done) begin
            create_block1 <= 1'b1;
            create_block2 <= multi;
          end
        end
        S_PLAY: begin
          if (created1 && create_block1) create_block1 <= 1'b0;
          if (created2 && create_block2) create_block2 <= 1'b0;
          if (grant1 && code_ok) begin
            next1 <= rand_piece;
            pend1 <= 1'b0;
          end
          if (grant2 && code_ok) begin
            next2 <= rand_piece;
            pend2 <= 1'b0;
          end
          if (pend1 && pend2 && code_ok) rr <= ~rr;
          if (defer1) def1 <= 1'b1;
          if (defer2) def2 <= 1'b1;
          // grant and apply never target the same player in one cycle
          if (apply1) begin
            curr1 <= next1; lock1 <= 1'b1; create_block1 <= 1'b1;
            pend1 <= 1'b1; def1 <= 1'b0;
          end
          if (apply2) begin
            curr2 <= next2; lock2 <= 1'b1; create_block2 <= 1'b1;
            pend2 <= 1'b1; def2 <= 1'b0;
          end
          if (over_hit) begin
            create_block1 <= 1'b0;
            create_block2 <= 1'b0;
            winner <= multi ? {game_over1, game_over2} : 2'b00;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
